// File: rtl/uart_wb_arb.sv
// Two-master round-robin arbiter in front of the UART register slave.
// One transaction per grant: IDLE -> ACTIVE -> DONE, with a timeout abort and master-abandon handling.
module uart_wb_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat,
    input  logic [3:0]  m0_sel,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdat,
    input  logic        m1_valid,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat,
    input  logic [3:0]  m1_sel,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdat,
    output logic        s_valid,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat,
    output logic [3:0]  s_sel,
    input  logic        s_ack,
    input  logic [31:0] s_rdat,
    output logic        grant,
    output logic        busy
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state, state_n;
    logic          grant_n;
    logic          last, last_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          g_valid;
    logic          g_we;
    logic [31:0]   g_adr;
    logic [31:0]   g_dat;
    logic [3:0]    g_sel;
    logic          ack_hit;
    logic          err_hit;

    // Request fields of the currently granted master
    always_comb begin
        g_valid = grant ? m1_valid : m0_valid;
        g_we    = grant ? m1_we    : m0_we;
        g_adr   = grant ? m1_adr   : m0_adr;
        g_dat   = grant ? m1_dat   : m0_dat;
        g_sel   = grant ? m1_sel   : m0_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        cnt_n   = cnt;
        ack_hit = 1'b0;
        err_hit = 1'b0;
        s_valid = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat   = '0;
        s_sel   = '0;
        busy    = (state != IDLE);

        case (state)
            IDLE: begin
                // Contention goes to the master that was not served last
                if (m0_valid || m1_valid) begin
                    grant_n = (m0_valid && m1_valid) ? ~last : m1_valid;
                    last_n  = grant_n;
                    cnt_n   = '0;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                s_valid = g_valid;
                s_we    = g_we;
                s_adr   = g_adr;
                s_dat   = g_dat;
                s_sel   = g_sel;
                // Abandon beats everything; a same-cycle ack beats the timeout
                if (!g_valid) begin
                    state_n = DONE;
                end else if (s_ack) begin
                    ack_hit = 1'b1;
                    state_n = DONE;
                end else if (cnt == CNT_LIMIT) begin
                    err_hit = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        m0_ack  = ack_hit && !grant;
        m1_ack  = ack_hit && grant;
        m0_err  = err_hit && !grant;
        m1_err  = err_hit && grant;
        m0_rdat = m0_ack ? s_rdat : '0;
        m1_rdat = m1_ack ? s_rdat : '0;
    end

endmodule

// File: doc/uart_wb_arb.md
UART_WB_ARB -- requirements
Module: uart_wb_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACTIVE cycles to wait for s_ack before aborting (legal 2..255).
REQ-002 SHALL have clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have m0_valid, m0_we  input  1 each  master-0 (CPU) request and write strobe.
REQ-005 SHALL have m0_adr, m0_dat  input  32 each  master-0 address and write data; m0_sel  input  4  byte selects.
REQ-006 SHALL have m0_ack  output  1 and m0_err  output  1  master-0 completion and timeout-abort pulses; m0_rdat  output  32  read data.
REQ-007 SHALL have m1_valid, m1_we, m1_adr, m1_dat, m1_sel, m1_ack, m1_err, m1_rdat, identical to master 0, for master 1 (DMA/bridge).
REQ-008 SHALL have s_valid, s_we  output  1 each; s_adr, s_dat  output  32 each; s_sel  output  4: shared request to the UART register slave.
REQ-009 SHALL have s_ack  input  1 and s_rdat  input  32: slave acknowledge and read data.
REQ-010 SHALL have grant  output  1  index of the current or last granted master; busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement the FSM IDLE -> ACTIVE -> DONE -> IDLE, with state, grant, the round-robin pointer last and the timeout counter cnt (8 bits) all registered.
REQ-012 In IDLE with exactly one mX_valid high, the arbiter SHALL set grant=X and move to ACTIVE on the next edge.
REQ-013 In IDLE with both valid high, the arbiter SHALL grant the master not equal to last; after reset last=1, so master 0 wins first.
REQ-014 On every transition into ACTIVE, the arbiter SHALL set last=grant and cnt=0.
REQ-015 In ACTIVE, s_valid SHALL equal m[grant]_valid, and s_adr/s_we/s_dat/s_sel SHALL be combinationally muxed from the granted master.
REQ-016 Outside ACTIVE, s_valid SHALL be 0 and s_adr/s_dat/s_sel/s_we SHALL be driven to 0.
REQ-017 In ACTIVE with s_valid and s_ack both high, the arbiter SHALL assert m[grant]_ack for exactly that cycle, drive m[grant]_rdat=s_rdat in that cycle, and move to DONE.
REQ-018 mX_rdat SHALL be 0 except during the ack cycle of master X.
REQ-019 DONE SHALL last exactly one cycle with s_valid=0, so the registered slave ack clears, and SHALL then return to IDLE; a new arbitration is evaluated only in IDLE.
REQ-020 Per-master minimum latency SHALL be: request seen in IDLE at cycle N, s_valid at N+1, ack at N+2 for a slave that acks one cycle after valid; the issue-to-issue spacing SHALL be 4 cycles.
REQ-021 In ACTIVE without s_ack, cnt SHALL increment by 1 per cycle and SHALL saturate at 255, never wrapping.
REQ-022 When cnt==TIMEOUT-1 and s_ack is low, the arbiter SHALL pulse m[grant]_err for one cycle, assert no ack, and move to DONE.
REQ-023 If s_ack and the timeout condition occur in the same cycle, ack SHALL win and err SHALL stay 0.
REQ-024 If m[grant]_valid drops in ACTIVE before ack (abandon), the arbiter SHALL move to DONE with no ack and no err.
REQ-025 s_ack received in IDLE or DONE SHALL be ignored: no master ack is generated.
REQ-026 The non-granted master SHALL see ack=0, err=0, rdat=0 and SHALL keep waiting; each master SHALL be served within one transaction of the other (no starvation).
REQ-027 mX_ack and mX_err SHALL never be high together, and at most one master SHALL be acked in any cycle.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force state=IDLE, grant=0, last=1, cnt=0.
REQ-029 While rst_n=0, all outputs SHALL be 0: s_*, mX_ack, mX_err, mX_rdat, busy.
REQ-030 Reset asserted mid-ACTIVE SHALL abort the transfer with no ack or err; after release, the first IDLE cycle SHALL arbitrate normally.

Verification
REQ-031 Single master-0 read: m0 read of 0x3000_0008, slave acks at N+2 with 0x0000_0005 -> m0_ack pulses at N+2 with m0_rdat=0x0000_0005; m1 outputs stay 0; busy is high for N+1..N+3.
REQ-032 Contention: m0 and m1 both valid continuously, m0 writing 0x3000_0004 data 0x41 and m1 reading 0x3000_0000 -> grants alternate 0,1,0,1, one ack per 4 cycles; s_dat=0x41 only during m0 ACTIVE.
REQ-033 Timeout: TIMEOUT=16, slave never acks -> m0_err pulses on the 16th ACTIVE cycle, no ack, IDLE two cycles later; the next m1 request is granted.
REQ-034 Ack/timeout collision: s_ack arrives on ACTIVE cycle 16 -> ack asserted, err stays 0.
REQ-035 Abandon and stale ack: m1 drops valid in ACTIVE -> DONE with no ack or err; then an s_ack pulse injected in IDLE -> no mX_ack.
REQ-036 Reset mid-transfer: rst_n low during ACTIVE -> all outputs 0 immediately; after release, m0 and m1 both valid -> m0 granted first.
